// File: rtl/neopixel_pixel_buffer.sv
// Pixel RAM shared by the CPU fill port and the NeoPixel driver's burst read port.
// Single-ported; the burst port has strict priority and reads are tagged by port.
module neopixel_pixel_buffer #(
  parameter int pDEPTH     = 4096,
  parameter int pADDR_BITS = $clog2(pDEPTH),
  parameter int pMAX_BURST = 23
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic [pADDR_BITS-1:0] iCPU_ADDRESS,
  input  logic                  iCPU_WRITE,
  input  logic [31:0]           iCPU_WRITE_DATA,
  input  logic [3:0]            iCPU_BYTE_ENABLE,
  input  logic                  iCPU_READ,
  output logic                  oCPU_WAIT_REQUEST,
  output logic [31:0]           oCPU_READ_DATA,
  output logic                  oCPU_READ_DATA_VALID,
  input  logic [31:0]           iDATA_ADDRESS,
  input  logic                  iDATA_READ,
  input  logic [4:0]            iDATA_BURST_COUNT,
  output logic                  oDATA_WAIT_REQUEST,
  output logic [31:0]           oDATA_READ_DATA,
  output logic                  oDATA_READ_DATA_VALID
);

  typedef enum logic {IDLE, BURST} stateT;

  stateT                 state;
  logic [pADDR_BITS-1:0] burstAddr;
  logic [4:0]            remaining;
  logic                  pipeValid;
  logic                  pipeIsData;

  logic [pADDR_BITS-1:0] dataWord;
  logic [4:0]            clampedCount;
  logic                  cpuGrant;
  logic                  cpuWriteEn;
  logic                  cpuReadEn;
  logic                  burstIssue;
  logic                  ramReadEn;
  logic [pADDR_BITS-1:0] ramAddr;
  logic [31:0]           ramQ;
  logic                  unusedAddrBits;

  assign dataWord       = iDATA_ADDRESS[pADDR_BITS+1:2];
  assign unusedAddrBits = ^{iDATA_ADDRESS[31:pADDR_BITS+2], iDATA_ADDRESS[1:0]};
  assign clampedCount   = (iDATA_BURST_COUNT > 5'(pMAX_BURST)) ? 5'(pMAX_BURST) : iDATA_BURST_COUNT;

  assign oDATA_WAIT_REQUEST = (state == BURST);
  assign oCPU_WAIT_REQUEST  = (state == BURST) || ((state == IDLE) && iDATA_READ);

  assign cpuGrant   = (state == IDLE) && !iDATA_READ;
  assign cpuWriteEn = cpuGrant && iCPU_WRITE;
  assign cpuReadEn  = cpuGrant && iCPU_READ && !iCPU_WRITE;

  // The first word of a burst is read on the accepting edge, so the RAM output
  // register plus the data output register still land valid one cycle after wait rises.
  assign burstIssue = ((state == IDLE) && iDATA_READ && (clampedCount != 5'd0)) ||
                      ((state == BURST) && (remaining != 5'd0));
  assign ramReadEn  = burstIssue || cpuReadEn;
  assign ramAddr    = (state == BURST) ? burstAddr : (iDATA_READ ? dataWord : iCPU_ADDRESS);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : genLane
      logic [7:0] laneMem [pDEPTH];
      logic [7:0] laneQ;

      always_ff @(posedge iCLOCK) begin
        if (cpuWriteEn && iCPU_BYTE_ENABLE[gi])
          laneMem[ramAddr] <= iCPU_WRITE_DATA[gi*8 +: 8];
        if (ramReadEn)
          laneQ <= laneMem[ramAddr];
      end

      assign ramQ[gi*8 +: 8] = laneQ;
    end
  endgenerate

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      state     <= IDLE;
      burstAddr <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iDATA_READ && (clampedCount != 5'd0)) begin
            burstAddr <= dataWord + pADDR_BITS'(1);
            remaining <= clampedCount - 5'd1;
            state     <= BURST;
          end
        end
        BURST: begin
          if (remaining == 5'd0) begin
            state <= IDLE;
          end else begin
            burstAddr <= burstAddr + pADDR_BITS'(1);
            remaining <= remaining - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port tag follows each read; only the owning port's outputs move.
  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      pipeValid             <= 1'b0;
      pipeIsData            <= 1'b0;
      oDATA_READ_DATA_VALID <= 1'b0;
      oDATA_READ_DATA       <= '0;
      oCPU_READ_DATA_VALID  <= 1'b0;
      oCPU_READ_DATA        <= '0;
    end else begin
      pipeValid             <= ramReadEn;
      pipeIsData            <= burstIssue;
      oDATA_READ_DATA_VALID <= pipeValid && pipeIsData;
      oCPU_READ_DATA_VALID  <= pipeValid && !pipeIsData;
      if (pipeValid && pipeIsData)
        oDATA_READ_DATA <= ramQ;
      if (pipeValid && !pipeIsData)
        oCPU_READ_DATA <= ramQ;
    end
  end

endmodule

// File: tb/tb_neopixel_pixel_buffer.sv
// Directed plus randomized checks of neopixel_pixel_buffer against a cycle-indexed
// behavioural model of the burst and CPU ports.
module tb_neopixel_pixel_buffer;
  localparam int DEPTH = 4096;
  localparam int MAXB  = 23;

  logic        iCLOCK = 1'b0;
  logic        iRESET;
  logic [11:0] iCPU_ADDRESS;
  logic        iCPU_WRITE;
  logic [31:0] iCPU_WRITE_DATA;
  logic [3:0]  iCPU_BYTE_ENABLE;
  logic        iCPU_READ;
  logic        oCPU_WAIT_REQUEST;
  logic [31:0] oCPU_READ_DATA;
  logic        oCPU_READ_DATA_VALID;
  logic [31:0] iDATA_ADDRESS;
  logic        iDATA_READ;
  logic [4:0]  iDATA_BURST_COUNT;
  logic        oDATA_WAIT_REQUEST;
  logic [31:0] oDATA_READ_DATA;
  logic        oDATA_READ_DATA_VALID;

  neopixel_pixel_buffer dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iCPU_ADDRESS(iCPU_ADDRESS), .iCPU_WRITE(iCPU_WRITE),
    .iCPU_WRITE_DATA(iCPU_WRITE_DATA), .iCPU_BYTE_ENABLE(iCPU_BYTE_ENABLE),
    .iCPU_READ(iCPU_READ), .oCPU_WAIT_REQUEST(oCPU_WAIT_REQUEST),
    .oCPU_READ_DATA(oCPU_READ_DATA), .oCPU_READ_DATA_VALID(oCPU_READ_DATA_VALID),
    .iDATA_ADDRESS(iDATA_ADDRESS), .iDATA_READ(iDATA_READ),
    .iDATA_BURST_COUNT(iDATA_BURST_COUNT), .oDATA_WAIT_REQUEST(oDATA_WAIT_REQUEST),
    .oDATA_READ_DATA(oDATA_READ_DATA), .oDATA_READ_DATA_VALID(oDATA_READ_DATA_VALID)
  );

  always #5 iCLOCK = ~iCLOCK;

  int compared = 0;
  int mismatched = 0;

  // Model state: cycle index counts intervals after each rising edge.
  int          cyc = 0;
  int          busyUntil = -1;
  int          acceptCount = 0;
  bit          cpuGranted;
  logic [31:0] mem [DEPTH];
  logic [31:0] expData [int];
  logic [31:0] expCpu [int];
  logic [31:0] lastData = '0;
  logic [31:0] lastCpu = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    bit busy;
    busy = (cyc <= busyUntil);
    chk("data_wait", 32'(oDATA_WAIT_REQUEST), 32'(busy));
    chk("cpu_wait", 32'(oCPU_WAIT_REQUEST), 32'(busy || iDATA_READ));
    chk("data_valid", 32'(oDATA_READ_DATA_VALID), 32'(expData.exists(cyc)));
    if (expData.exists(cyc)) lastData = expData[cyc];
    chk("data_value", oDATA_READ_DATA, lastData);
    chk("cpu_valid", 32'(oCPU_READ_DATA_VALID), 32'(expCpu.exists(cyc)));
    if (expCpu.exists(cyc)) lastCpu = expCpu[cyc];
    chk("cpu_value", oCPU_READ_DATA, lastCpu);
  endtask

  // Apply the model's view of the coming edge, advance one clock, then compare.
  task automatic step();
    int n;
    int w;
    cpuGranted = 1'b0;
    if (cyc > busyUntil) begin
      if (iDATA_READ) begin
        n = (int'(iDATA_BURST_COUNT) > MAXB) ? MAXB : int'(iDATA_BURST_COUNT);
        w = int'(iDATA_ADDRESS[13:2]);
        acceptCount++;
        if (n > 0) busyUntil = cyc + n;
        for (int i = 0; i < n; i++) expData[cyc + 2 + i] = mem[(w + i) % DEPTH];
        $display("burst accepted cycle=%0d word=%0d count=%0d", cyc, w, n);
      end else begin
        cpuGranted = 1'b1;
        if (iCPU_WRITE) begin
          for (int b = 0; b < 4; b++)
            if (iCPU_BYTE_ENABLE[b]) mem[iCPU_ADDRESS][b*8 +: 8] = iCPU_WRITE_DATA[b*8 +: 8];
        end else if (iCPU_READ) begin
          expCpu[cyc + 2] = mem[iCPU_ADDRESS];
          $display("cpu read cycle=%0d word=%0d", cyc, iCPU_ADDRESS);
        end
      end
    end
    @(posedge iCLOCK);
    #1;
    cyc++;
    checkOutputs();
  endtask

  task automatic cpuWrite(input int a, input logic [31:0] d, input logic [3:0] be);
    iCPU_ADDRESS = 12'(a); iCPU_WRITE_DATA = d; iCPU_BYTE_ENABLE = be; iCPU_WRITE = 1'b1;
    step();
    iCPU_WRITE = 1'b0;
  endtask

  task automatic burst(input logic [31:0] addr, input logic [4:0] cnt);
    iDATA_ADDRESS = addr; iDATA_BURST_COUNT = cnt; iDATA_READ = 1'b1;
    step();
    iDATA_READ = 1'b0;
  endtask

  task automatic pulseReset();
    iRESET = 1'b0;
    #2;
    busyUntil = -1;
    expData.delete();
    expCpu.delete();
    lastData = '0;
    lastCpu = '0;
    checkOutputs();
    $display("reset asserted cycle=%0d", cyc);
    @(posedge iCLOCK);
    #1;
    cyc++;
    checkOutputs();
    iRESET = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int guard;

    iRESET = 1'b0;
    iCPU_ADDRESS = '0; iCPU_WRITE = 1'b0; iCPU_WRITE_DATA = '0; iCPU_BYTE_ENABLE = '0;
    iCPU_READ = 1'b0; iDATA_ADDRESS = '0; iDATA_READ = 1'b0; iDATA_BURST_COUNT = '0;
    repeat (2) @(posedge iCLOCK);
    #1;
    checkOutputs();
    iRESET = 1'b1;

    // Fill words 0..127; words 0..22 carry the known ramp.
    for (int k = 0; k < 128; k++) begin
      r = $urandom;
      cpuWrite(k, (k < 23) ? 32'h00AA0000 + 32'(k) : r, 4'hF);
    end

    // Full-length burst from word 0.
    burst(32'h0, 5'd23);
    repeat (25) step();

    // Back-to-back bursts with the request held through the wait.
    iDATA_ADDRESS = 32'h5C; iDATA_BURST_COUNT = 5'd23; iDATA_READ = 1'b1;
    step();
    iDATA_ADDRESS = 32'hB8;
    guard = 0;
    while (acceptCount < 3 && guard < 60) begin step(); guard++; end
    iDATA_READ = 1'b0;
    repeat (26) step();

    // CPU write stalled behind a burst, with a single byte lane enabled.
    cpuWrite(5, 32'hFFFFFFFF, 4'hF);
    burst(32'h0, 5'd23);
    iCPU_ADDRESS = 12'd5; iCPU_WRITE_DATA = 32'h12345678; iCPU_BYTE_ENABLE = 4'b0010;
    iCPU_WRITE = 1'b1;
    guard = 0;
    do begin step(); guard++; end while (!cpuGranted && guard < 60);
    iCPU_WRITE = 1'b0;
    iCPU_READ = 1'b1;
    step();
    iCPU_READ = 1'b0;
    step();
    chk("be_merge", oCPU_READ_DATA, 32'hFFFF56FF);
    chk("be_valid", 32'(oCPU_READ_DATA_VALID), 32'd1);

    // Wrap at the top of memory, upper and low address bits ignored.
    cpuWrite(DEPTH - 2, 32'hC0DE0FFE, 4'hF);
    cpuWrite(DEPTH - 1, 32'hC0DE0FFF, 4'hF);
    burst(32'hABCD3FFB, 5'd4);
    repeat (3) step();
    chk("wrap_w2", oDATA_READ_DATA, mem[0]);
    step();
    chk("wrap_w3", oDATA_READ_DATA, mem[1]);
    step();
    burst(32'h10, 5'd0);
    chk("zero_wait", 32'(oDATA_WAIT_REQUEST), 32'd0);
    repeat (3) step();
    burst(32'h20, 5'd31);
    repeat (26) step();

    // Reset in the middle of a burst, then a fresh burst.
    burst(32'h0, 5'd23);
    repeat (4) step();
    pulseReset();
    repeat (25) step();
    burst(32'h40, 5'd5);
    repeat (7) step();

    // Lone CPU read.
    iCPU_ADDRESS = 12'd7; iCPU_READ = 1'b1;
    step();
    iCPU_READ = 1'b0;
    step();
    chk("cpu_rd7", oCPU_READ_DATA, mem[7]);
    chk("cpu_rd7_no_data_valid", 32'(oDATA_READ_DATA_VALID), 32'd0);

    // Randomized traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      iDATA_READ = ($urandom_range(0, 3) == 0);
      iDATA_ADDRESS = {r[31:14], 12'($urandom_range(0, 96)), r[1:0]};
      iDATA_BURST_COUNT = 5'($urandom_range(0, 31));
      r = $urandom;
      iCPU_WRITE = r[0];
      iCPU_READ = r[1];
      iCPU_BYTE_ENABLE = r[5:2];
      iCPU_ADDRESS = 12'($urandom_range(0, 127));
      iCPU_WRITE_DATA = $urandom;
      step();
    end
    iDATA_READ = 1'b0; iCPU_WRITE = 1'b0; iCPU_READ = 1'b0;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
